ws_bank_scheduler: RTL and testbench

- Sequences the double-buffered LED frame store between the SPI frame writer and the ws2812 serial driver.
- Owns bank assignment: the writer always fills the non-displayed bank.
- Swaps banks only at a driver frame boundary (rising edge of reset_state), so a displayed frame is never torn.
- Translates driver address/data_request into frame-store reads and supplies red/green/blue to the driver, blanking LEDs beyond the committed frame length.

---
 rtl/ws_bank_scheduler.sv | 158 +++++++++++++++
 tb/tb_ws_bank_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws_bank_scheduler.sv
// Double-buffered LED frame-store scheduler between the SPI frame writer and the ws2812 driver.
// Optional brightness scaling is enabled by defining BRIGHTNESS_SCALE_EN.
module ws_bank_scheduler #(
  parameter int NUM_LEDS = 16,
  parameter int AW       = $clog2(NUM_LEDS),
  parameter int CW       = $clog2(NUM_LEDS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_start,
  input  logic          wr_done,
  input  logic [CW-1:0] wr_count,
  output logic          wr_bank,
  input  logic          ws_reset_state,
  input  logic          ws_data_request,
  input  logic [AW-1:0] ws_address,
  output logic [AW:0]   mem_rd_addr,
  input  logic [23:0]   mem_rd_data,
  output logic [7:0]    red_out,
  output logic [7:0]    green_out,
  output logic [7:0]    blue_out,
  output logic          disp_bank,
  output logic          swap_pulse,
  output logic [7:0]    drop_count
`ifdef BRIGHTNESS_SCALE_EN
  ,
  input  logic [7:0]    bright_in,
  input  logic          bright_load
`endif
);

  localparam int STAGES = 1;
  localparam logic [AW:0]   BANK_OFS = (AW+1)'(NUM_LEDS);
  localparam logic [CW-1:0] MAX_CNT  = CW'(NUM_LEDS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PEND} state_t;

  state_t        state, state_n;
  logic          rs_q;
  logic          swap_go;
  logic          drop_inc;
  logic          latch_pend;
  logic [CW-1:0] pend_count;
  logic [CW-1:0] disp_count;

  logic [STAGES:0] vld_pipe;
  logic            blank_q;
  logic [23:0]     col_live;
  logic [23:0]     col_q;
  logic [23:0]     col_out;

  assign wr_bank = ~disp_bank;
  // A swap commits only at a driver frame boundary, so the displayed frame is never torn.
  assign swap_go = (state == S_PEND) & ws_reset_state & ~rs_q;

  always_comb begin
    state_n    = state;
    drop_inc   = 1'b0;
    latch_pend = 1'b0;
    case (state)
      S_IDLE: if (wr_start) state_n = S_FILL;
      S_FILL: begin
        if (wr_start) state_n = S_FILL;
        else if (wr_done) begin
          if (wr_count == '0) state_n = S_IDLE;
          else begin
            state_n    = S_PEND;
            latch_pend = 1'b1;
          end
        end
      end
      S_PEND: begin
        // A new frame replaces the pending one unless the pending one is being shown now.
        if (wr_start) begin
          state_n  = S_FILL;
          drop_inc = ~swap_go;
        end else if (swap_go) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rs_q       <= 1'b0;
      disp_bank  <= 1'b0;
      disp_count <= '0;
      pend_count <= '0;
      swap_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      state      <= state_n;
      rs_q       <= ws_reset_state;
      swap_pulse <= swap_go;
      if (latch_pend) pend_count <= (wr_count > MAX_CNT) ? MAX_CNT : wr_count;
      if (swap_go) begin
        disp_bank  <= ~disp_bank;
        disp_count <= pend_count;
      end
      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  assign mem_rd_addr = disp_bank ? {1'b0, ws_address} : ({1'b0, ws_address} + BANK_OFS);
  assign vld_pipe[0] = ws_data_request;
  assign col_live    = blank_q ? 24'h0 : mem_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[STAGES:1] <= '0;
      blank_q            <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (ws_data_request) blank_q <= (CW'(ws_address) >= disp_count);
    end
  end

`ifdef BRIGHTNESS_SCALE_EN
  logic [7:0] bright_shadow, bright_act;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] a);
    logic [15:0] p;
    p = 16'(c) * 16'(a) + 16'(c);
    return 8'(p >> 8);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      bright_shadow <= 8'hFF;
      bright_act    <= 8'hFF;
      col_q         <= '0;
    end else begin
      if (bright_load) bright_shadow <= bright_in;
      if (swap_go) bright_act <= bright_shadow;
      if (vld_pipe[1])
        col_q <= {scale(col_live[23:16], bright_act), scale(col_live[15:8], bright_act),
                  scale(col_live[7:0], bright_act)};
    end
  end

  // Scaled colours come from the extra register stage.
  assign col_out = col_q;
`else
  always_ff @(posedge clk) begin
    if (reset) col_q <= '0;
    else if (vld_pipe[1]) col_q <= col_live;
  end

  // Present the read data in the cycle it arrives, then hold it.
  assign col_out = vld_pipe[1] ? col_live : col_q;
`endif

  assign green_out = col_out[23:16];
  assign red_out   = col_out[15:8];
  assign blue_out  = col_out[7:0];

endmodule

// File: tb/tb_ws_bank_scheduler.sv
// Randomized scoreboard bench for ws_bank_scheduler against a frame-level reference model.
module tb_ws_bank_scheduler;
  localparam int NUM = 16;
  localparam int AW  = 4;
  localparam int CW  = 5;
  localparam int M_IDLE = 0, M_FILL = 1, M_PEND = 2;

  logic clk = 1'b0;
  logic reset, wr_start, wr_done, ws_reset_state, ws_data_request, bright_load;
  logic [CW-1:0] wr_count;
  logic [AW-1:0] ws_address;
  logic [7:0]    bright_in;
  logic          wr_bank, disp_bank, swap_pulse;
  logic [AW:0]   mem_rd_addr;
  logic [23:0]   mem_rd_data;
  logic [7:0]    red_out, green_out, blue_out, drop_count;

  always #5 clk = ~clk;

  ws_bank_scheduler #(.NUM_LEDS(NUM)) dut (
    .clk(clk), .reset(reset), .wr_start(wr_start), .wr_done(wr_done), .wr_count(wr_count),
    .wr_bank(wr_bank), .ws_reset_state(ws_reset_state), .ws_data_request(ws_data_request),
    .ws_address(ws_address), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .disp_bank(disp_bank),
    .swap_pulse(swap_pulse), .drop_count(drop_count)
`ifdef BRIGHTNESS_SCALE_EN
    , .bright_in(bright_in), .bright_load(bright_load)
`endif
  );

  // Frame store: two banks, 1-cycle synchronous read.
  logic [23:0] mem [2*NUM];
  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  // Reference model: whole frames, not registers.
  logic [23:0] m_frame [NUM];
  logic [23:0] m_pframe [NUM];
  logic [23:0] m_fill [NUM];
  int   m_state = M_IDLE, m_cnt = 0, m_pcnt = 0, m_drop = 0;
  bit   m_disp = 1'b0, m_swap = 1'b0, m_rs = 1'b0, m_sw;
  logic [7:0] m_act = 8'hFF, m_shadow = 8'hFF, act_d = 8'hFF;

  logic [23:0] exp_q [$];
  logic [23:0] mon_e;
  logic req_d1 = 1'b0, req_d2 = 1'b0;
  bit   started = 1'b0;
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sc(input logic [7:0] c, input logic [7:0] a);
    return 8'((int'(c) * (int'(a) + 1)) / 256);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_disp = 0; m_cnt = 0; m_state = M_IDLE; m_drop = 0; m_swap = 0; m_rs = 0;
      m_act = 8'hFF; m_shadow = 8'hFF;
    end else begin
      m_sw   = (m_state == M_PEND) && ws_reset_state && !m_rs;
      m_swap = m_sw;
      if (m_sw) begin
        m_disp = !m_disp; m_cnt = m_pcnt; m_frame = m_pframe; m_act = m_shadow;
      end
      if (bright_load) m_shadow = bright_in;
      if (wr_start) begin
        if (m_state == M_PEND && !m_sw && m_drop < 255) m_drop++;
        m_state = M_FILL;
      end else if (wr_done && m_state == M_FILL) begin
        if (wr_count == 0) m_state = M_IDLE;
        else begin
          m_state = M_PEND;
          m_pcnt  = (int'(wr_count) > NUM) ? NUM : int'(wr_count);
          m_pframe = m_fill;
        end
      end else if (m_sw) m_state = M_IDLE;
      m_rs = ws_reset_state;
    end
  end

  always @(posedge clk) begin
    req_d1 <= reset ? 1'b0 : ws_data_request;
    req_d2 <= reset ? 1'b0 : req_d1;
  end

  // Monitor: pops one expectation per presented colour, checks status every cycle.
  always @(negedge clk) if (started) begin
`ifdef BRIGHTNESS_SCALE_EN
    if (req_d2) begin
`else
    if (req_d1) begin
`endif
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: got colour with no expectation at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
`ifdef BRIGHTNESS_SCALE_EN
        mon_e = {sc(mon_e[23:16], act_d), sc(mon_e[15:8], act_d), sc(mon_e[7:0], act_d)};
`endif
        chk("colour", {8'h0, green_out, red_out, blue_out}, {8'h0, mon_e});
      end
    end
    chk("wr_bank", 32'(wr_bank), 32'(!m_disp));
    chk("disp_bank", 32'(disp_bank), 32'(m_disp));
    chk("swap_pulse", 32'(swap_pulse), 32'(m_swap));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    act_d = m_act;
  end

  task automatic drive(input logic rst, input logic st, input logic dn, input logic [CW-1:0] cnt,
                       input logic rs, input logic req, input logic [AW-1:0] a,
                       input logic bl = 1'b0, input logic [7:0] bi = 8'h0);
    logic [23:0] w;
    @(negedge clk);
    reset = rst; wr_start = st; wr_done = dn; wr_count = cnt; ws_reset_state = rs;
    ws_data_request = req; ws_address = a; bright_load = bl; bright_in = bi;
    if (st && !rst) begin
      // Writer fills the whole non-displayed bank at frame start.
      for (int i = 0; i < NUM; i++) begin
        w = 24'($urandom);
        mem[i + (m_disp ? NUM : 0)] = w;
        m_fill[i] = w;
      end
    end
    if (req && !rst) exp_q.push_back((int'(a) < m_cnt) ? m_frame[a] : 24'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sweep();
    for (int a = 0; a < NUM; a++) drive(0, 0, 0, 0, 0, 1, 4'(a));
    idle(3);
  endtask

  task automatic edge_rs();
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2*NUM; i++) mem[i] = 24'h0;
    for (int i = 0; i < NUM; i++) begin m_frame[i] = 0; m_pframe[i] = 0; m_fill[i] = 0; end
    reset = 1; wr_start = 0; wr_done = 0; wr_count = 0; ws_reset_state = 0;
    ws_data_request = 0; ws_address = 0; bright_load = 0; bright_in = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    started = 1;
    sweep();                                    // empty display: all black

    drive(0, 1, 0, 0, 0, 0, 0, 1'b1, 8'h7F);    // first frame, count 5
    mem[m_disp ? NUM : 0] = 24'hFF8040; m_fill[0] = 24'hFF8040;
    mem[1 + (m_disp ? NUM : 0)] = 24'h102030; m_fill[1] = 24'h102030;
    idle(2);
    drive(0, 0, 1, 5, 0, 0, 0);
    idle(1);
    edge_rs();
    sweep();

    drive(0, 1, 0, 0, 0, 0, 0); drive(0, 0, 1, 3, 0, 0, 0);  // overwritten frame
    drive(0, 1, 0, 0, 0, 0, 0); drive(0, 0, 1, 7, 0, 0, 0);
    edge_rs();
    sweep();

    drive(0, 1, 0, 0, 0, 0, 0);                 // edges while filling do not swap
    edge_rs();
    drive(0, 0, 1, 4, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    edge_rs();
    sweep();

    drive(0, 1, 0, 0, 0, 0, 0); drive(0, 0, 1, 20, 0, 0, 0);  // count saturates at NUM
    edge_rs();
    sweep();

    drive(0, 1, 0, 0, 0, 0, 0); drive(0, 0, 1, 0, 0, 0, 0);   // empty frame ignored
    edge_rs();

    drive(0, 1, 0, 0, 0, 0, 0); drive(0, 0, 1, 6, 0, 0, 0);  // reset discards pending
    do_reset();
    edge_rs();
    sweep();

    for (int i = 0; i < 260; i++) begin         // drop counter saturation
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 2, 0, 0, 0);
    end
    idle(2);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      logic rs, st, dn, req;
      int ev;
      if ($urandom_range(0, 399) == 0) do_reset();
      rs  = ($urandom_range(0, 5) == 0);
      ev  = $urandom_range(0, 9);
      st  = (ev == 0) && !rs;
      dn  = (ev == 1 || ev == 2);
      req = $urandom_range(0, 1) == 1;
      drive(0, st, dn, 5'($urandom_range(0, 20)), rs, req, 4'($urandom),
            ($urandom_range(0, 15) == 0), 8'($urandom));
    end
    idle(4);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
